// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with merged control decode and an iterative multiplier.
// Single-cycle ops return one cycle after issue; MUL retires MUL_BITS bits per cycle.
module alu_exec_unit #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MUL_BITS = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic [9:0]       funct_i,
   input  logic [1:0]       ALUOp_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             busy_o
);

   localparam int unsigned N  = WIDTH / MUL_BITS;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned SH = $clog2(WIDTH);

   typedef enum logic {S_IDLE, S_MUL} state_t;
   typedef enum logic [2:0] {
      OP_ADD, OP_SUB, OP_MUL, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRA
   } op_t;

   state_t           r_state, w_state_nxt;
   op_t              w_op;
   logic             w_accept;
   logic             w_fin;
   logic [6:0]       w_f7;
   logic [2:0]       w_f3;
   logic [SH-1:0]    w_shamt;
   logic [WIDTH-1:0] w_alu;
   logic [WIDTH-1:0] w_pp;
   logic [WIDTH-1:0] w_sum;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_valid;

   assign w_f7     = funct_i[9:3];
   assign w_f3     = funct_i[2:0];
   assign w_shamt  = data2_i[SH-1:0];
   assign ready_o  = (r_state == S_IDLE);
   assign busy_o   = (r_state == S_MUL);
   assign w_accept = valid_i && ready_o;
   assign valid_o  = r_valid;
   assign result_o = r_result;
   assign zero_o   = r_zero;

   always_comb begin
      w_op = OP_ADD;
      case (ALUOp_i)
         2'b00: w_op = OP_ADD;
         2'b01: w_op = OP_SUB;
         2'b10: begin
            case (w_f3)
               3'b000: begin
                  if (w_f7 == 7'b0100000)      w_op = OP_SUB;
                  else if (w_f7 == 7'b0000001) w_op = OP_MUL;
                  else                         w_op = OP_ADD;
               end
               3'b100: w_op = OP_XOR;
               3'b110: w_op = OP_OR;
               3'b111: w_op = OP_AND;
               3'b001: if (w_f7 == 7'b0000000) w_op = OP_SLL;
               default: w_op = OP_ADD;
            endcase
         end
         default: begin
            if (w_f3 == 3'b101 && w_f7 == 7'b0100000) w_op = OP_SRA;
         end
      endcase
   end

   always_comb begin
      w_alu = data1_i + data2_i;
      case (w_op)
         OP_SUB:  w_alu = data1_i - data2_i;
         OP_XOR:  w_alu = data1_i ^ data2_i;
         OP_OR:   w_alu = data1_i | data2_i;
         OP_AND:  w_alu = data1_i & data2_i;
         OP_SLL:  w_alu = data1_i << w_shamt;
         OP_SRA:  w_alu = $signed(data1_i) >>> w_shamt;
         default: w_alu = data1_i + data2_i;
      endcase
   end

   // Multiplicand is pre-shifted and multiplier consumed from the LSB each
   // cycle, so the current slice always sits at the bottom of r_mplier.
   always_comb begin
      w_pp = '0;
      for (int unsigned i = 0; i < MUL_BITS; i++) begin
         if (r_mplier[i]) w_pp = w_pp + (r_mcand << i);
      end
      w_sum = r_acc + w_pp;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fin       = 1'b0;
      case (r_state)
         S_IDLE: if (w_accept && w_op == OP_MUL) w_state_nxt = S_MUL;
         S_MUL: begin
            if (r_cnt == CW'(N - 1)) begin
               w_fin       = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_result <= '0;
         r_zero   <= 1'b1;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_state == S_IDLE) begin
            if (w_accept) begin
               if (w_op == OP_MUL) begin
                  r_mcand  <= data1_i;
                  r_mplier <= data2_i;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end else begin
                  r_result <= w_alu;
                  r_zero   <= (w_alu == '0);
                  r_valid  <= 1'b1;
               end
            end
         end else begin
            r_acc    <= w_sum;
            r_mcand  <= r_mcand << MUL_BITS;
            r_mplier <= r_mplier >> MUL_BITS;
            r_cnt    <= r_cnt + 1'b1;
            if (w_fin) begin
               r_result <= w_sum;
               r_zero   <= (w_sum == '0);
               r_valid  <= 1'b1;
               r_cnt    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized bench for alu_exec_unit against a behavioural model
// (plain arithmetic for every op, 64-bit product for MUL).
module tb_alu_exec_unit;

   logic        clk, rst, vld, vld4;
   logic [9:0]  funct;
   logic [1:0]  aluop;
   logic [31:0] d1, d2;
   logic        rdy, vo, zo, bsy;
   logic [31:0] res;
   logic        rdy4, vo4, zo4, bsy4;
   logic [31:0] res4;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] F_MUL = {7'b0000001, 3'b000};

   alu_exec_unit #(.WIDTH(32), .MUL_BITS(1)) dut (
      .clk_i(clk), .rst_i(rst), .valid_i(vld), .funct_i(funct), .ALUOp_i(aluop),
      .data1_i(d1), .data2_i(d2), .ready_o(rdy), .valid_o(vo), .result_o(res),
      .zero_o(zo), .busy_o(bsy));

   alu_exec_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .valid_i(vld4), .funct_i(funct), .ALUOp_i(aluop),
      .data1_i(d1), .data2_i(d2), .ready_o(rdy4), .valid_o(vo4), .result_o(res4),
      .zero_o(zo4), .busy_o(bsy4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_mul(input logic [1:0] op, input logic [9:0] f);
      return (op == 2'b10) && (f == F_MUL);
   endfunction

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [9:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [63:0] p;
      f7 = f[9:3];
      f3 = f[2:0];
      p  = 64'(a) * 64'(b);
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      if (op == 2'b10) begin
         if (f3 == 3'b000 && f7 == 7'h20) return a - b;
         if (f3 == 3'b000 && f7 == 7'h01) return p[31:0];
         if (f3 == 3'b100) return a ^ b;
         if (f3 == 3'b110) return a | b;
         if (f3 == 3'b111) return a & b;
         if (f3 == 3'b001 && f7 == 7'h00) return a << b[4:0];
         return a + b;
      end
      if (f3 == 3'b101 && f7 == 7'h20) return 32'($signed(a) >>> b[4:0]);
      return a + b;
   endfunction

   // Accept one single-cycle op; leaves vld high so consecutive calls are back-to-back.
   task automatic issue(input logic [1:0] op, input logic [9:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string tag);
      aluop = op; funct = f; d1 = a; d2 = b; vld = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(vo), 32'd1);
      chk({tag, "_result"}, res, exp);
      chk({tag, "_zero"}, 32'(zo), 32'(exp == 32'd0));
      chk({tag, "_ready"}, 32'(rdy), 32'd1);
   endtask

   task automatic idle();
      vld = 1'b0;
      @(posedge clk); #1;
      chk("idle_valid", 32'(vo), 32'd0);
   endtask

   task automatic mul_run(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
      bit ok;
      aluop = 2'b10; funct = F_MUL; d1 = a; d2 = b; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      ok = (rdy === 1'b0) && (bsy === 1'b1) && (vo === 1'b0);
      for (int k = 1; k < 32; k++) begin
         @(posedge clk); #1;
         if (!((rdy === 1'b0) && (bsy === 1'b1) && (vo === 1'b0))) ok = 0;
      end
      chk({tag, "_stall"}, 32'(ok), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_valid"}, 32'(vo), 32'd1);
      chk({tag, "_result"}, res, exp);
      chk({tag, "_zero"}, 32'(zo), 32'(exp == 32'd0));
      chk({tag, "_ready"}, 32'(rdy), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'(vo), 32'd0);
   endtask

   initial begin
      logic [9:0]  ftab [10];
      logic [1:0]  rop;
      logic [9:0]  rf;
      logic [31:0] ra, rb;
      bit          ok;
      bit          seen;

      ftab = '{{7'h00, 3'b000}, {7'h20, 3'b000}, {7'h01, 3'b000}, {7'h00, 3'b100},
               {7'h00, 3'b110}, {7'h00, 3'b111}, {7'h00, 3'b001}, {7'h20, 3'b101},
               {7'h00, 3'b101}, {7'h00, 3'b010}};
      rst = 1'b0; vld = 1'b0; vld4 = 1'b0;
      aluop = '0; funct = '0; d1 = '0; d2 = '0;

      // asynchronous reset, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_busy", 32'(bsy), 32'd0);
      chk("rst_valid", 32'(vo), 32'd0);
      chk("rst_result", res, 32'd0);
      chk("rst_zero", 32'(zo), 32'd1);
      chk("rst4_ready", 32'(rdy4), 32'd1);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      idle();

      issue(2'b10, 10'h000, 32'd5, 32'd7, 32'd12, "add");
      issue(2'b01, 10'h000, 32'd3, 32'd5, 32'hFFFF_FFFE, "sub");
      issue(2'b01, 10'h000, 32'd9, 32'd9, 32'd0, "sub_zero");
      idle();

      issue(2'b10, {7'h00, 3'b111}, 32'hF0F0_1234, 32'h0000_00FF, 32'h0000_0034, "and");
      issue(2'b10, {7'h00, 3'b110}, 32'hF0F0_1234, 32'h0000_00FF, 32'hF0F0_12FF, "or");
      issue(2'b10, {7'h00, 3'b100}, 32'hF0F0_1234, 32'h0000_00FF, 32'hF0F0_12CB, "xor");
      issue(2'b10, {7'h00, 3'b001}, 32'hF0F0_1234, 32'h0000_00FF, 32'h0000_0000, "sll31");
      issue(2'b10, {7'h00, 3'b001}, 32'hF0F0_1234, 32'h0000_0004, 32'h0F01_2340, "sll4");
      issue(2'b11, {7'h20, 3'b101}, 32'h8000_0000, 32'd4, 32'hF800_0000, "srai");
      issue(2'b10, {7'h00, 3'b010}, 32'd5, 32'd7, 32'd12, "undef_add");
      idle();

      // MUL with an ADD held on the inputs behind it
      aluop = 2'b10; funct = F_MUL; d1 = 32'd6; d2 = 32'd7; vld = 1'b1;
      @(posedge clk); #1;
      aluop = 2'b00; funct = 10'h000; d1 = 32'd100; d2 = 32'd23;
      ok = (rdy === 1'b0) && (bsy === 1'b1) && (vo === 1'b0);
      for (int k = 1; k < 32; k++) begin
         @(posedge clk); #1;
         if (!((rdy === 1'b0) && (vo === 1'b0))) ok = 0;
      end
      chk("mq_stall", 32'(ok), 32'd1);
      @(posedge clk); #1;
      chk("mq_valid33", 32'(vo), 32'd1);
      chk("mq_result33", res, 32'd42);
      chk("mq_ready33", 32'(rdy), 32'd1);
      @(posedge clk); #1;
      chk("mq_valid34", 32'(vo), 32'd1);
      chk("mq_result34", res, 32'd123);
      idle();

      mul_run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_wrap");
      mul_run(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, "mul_zero");

      // reset during cycle 10 of a multiply
      aluop = 2'b10; funct = F_MUL; d1 = 32'd11; d2 = 32'd13; vld = 1'b1;
      @(posedge clk); #1;
      vld = 1'b0;
      repeat (9) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("mrst_ready", 32'(rdy), 32'd1);
      chk("mrst_busy", 32'(bsy), 32'd0);
      chk("mrst_valid", 32'(vo), 32'd0);
      chk("mrst_result", res, 32'd0);
      chk("mrst_zero", 32'(zo), 32'd1);
      #1 rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (vo !== 1'b0) seen = 1;
      end
      chk("mrst_no_valid", 32'(seen), 32'd0);
      mul_run(32'd3, 32'd5, 32'd15, "mul_after_rst");
      issue(2'b00, 10'h000, 32'd1, 32'd2, 32'd3, "add_after_rst");
      idle();

      // MUL_BITS = 4 instance: N = 8, result in cycle 9
      aluop = 2'b10; funct = F_MUL; d1 = 32'd6; d2 = 32'd7; vld4 = 1'b1;
      @(posedge clk); #1;
      vld4 = 1'b0;
      ok = (rdy4 === 1'b0) && (bsy4 === 1'b1) && (vo4 === 1'b0);
      for (int k = 1; k < 8; k++) begin
         @(posedge clk); #1;
         if (!((rdy4 === 1'b0) && (vo4 === 1'b0))) ok = 0;
      end
      chk("m4_stall", 32'(ok), 32'd1);
      @(posedge clk); #1;
      chk("m4_valid9", 32'(vo4), 32'd1);
      chk("m4_result", res4, 32'd42);
      chk("m4_ready", 32'(rdy4), 32'd1);

      // randomized ops against the model
      for (int i = 0; i < 80; i++) begin
         rop = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) rf = 10'($urandom);
         else rf = ftab[$urandom_range(0, 9)];
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 5) == 0) rb = ra;
         if (is_mul(rop, rf)) begin
            mul_run(ra, rb, ref_res(rop, rf, ra, rb), $sformatf("rmul%0d", i));
         end else begin
            issue(rop, rf, ra, rb, ref_res(rop, rf, ra, rb), $sformatf("rop%0d", i));
            if ($urandom_range(0, 1) == 0) idle();
         end
      end
      idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage unit for the pipelined RISC-V core. It merges ALU control decode (ALUOp + funct7/funct3) with the datapath and adds an iterative multi-cycle multiplier. A valid/ready handshake lets the hazard unit stall issue while a multiply is in flight. Single-cycle ops return a registered result one cycle after issue; MUL returns after WIDTH/MUL_BITS + 1 cycles.

## Interface
- WIDTH, 32: operand and result width; must be >= 8.
- MUL_BITS, 1: multiplier bits retired per cycle; must divide WIDTH. Defines N = WIDTH/MUL_BITS.

- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  issue request; the op is accepted on an edge where valid_i && ready_o.
- funct_i  in  10  {funct7, funct3} of the instruction.
- ALUOp_i  in  2  00 = ADD, 01 = SUB, 10 = R-type decode, 11 = I-type decode.
- data1_i  in  WIDTH  operand A (rs1).
- data2_i  in  WIDTH  operand B (rs2 or immediate).
- ready_o  out  1  unit can accept an op this cycle.
- valid_o  out  1  one-cycle pulse; result_o/zero_o valid.
- result_o  out  WIDTH  registered result; holds its value between pulses.
- zero_o  out  1  registered (result_o == 0).
- busy_o  out  1  multiply in flight; equals !ready_o.

## Operation
- Decode, evaluated only at acceptance:
  - ALUOp 00 -> ADD.
  - ALUOp 01 -> SUB.
  - ALUOp 10, R-type, funct3 = 000: funct7 0000000 -> ADD; 0100000 -> SUB; 0000001 -> MUL.
  - ALUOp 10, R-type, other funct3: 100 -> XOR; 110 -> OR; 111 -> AND; 001 with funct7 0000000 -> SLL.
  - ALUOp 11, I-type: funct3 000 -> ADD; 101 with funct7 0100000 -> SRA by data2_i[4:0] (low log2(WIDTH) bits in general).
  - Any other encoding -> ADD. No error is flagged.
- Arithmetic is modulo 2^WIDTH and carries are discarded. MUL returns the low WIDTH bits of the product; this is identical for signed and unsigned operands.
- State machine with two states, IDLE and MUL.
  - IDLE: ready_o = 1.
  - Accept of a non-MUL op: compute the result, register result_o/zero_o, assert valid_o next cycle, stay in IDLE.
  - Accept of MUL: latch multiplicand = A and multiplier = B, clear the accumulator, set cnt = 0, go to MUL.
  - MUL: ready_o = 0. Each edge adds (multiplicand << (cnt*MUL_BITS)) * multiplier[cnt-th MUL_BITS slice] into the accumulator, then increments cnt.
  - On the edge where cnt == N-1: write the final sum to result_o/zero_o, pulse valid_o, return to IDLE.
- valid_i is ignored while in MUL; the op is neither queued nor accepted.
- Reset, including mid-multiply: state IDLE, cnt = 0, accumulator = 0. The pending multiply is dropped and no valid_o is produced for it.

## Timing
- Reset values:
  - ready_o = 1, busy_o = 0.
  - valid_o = 0, result_o = 0, zero_o = 1.
- Define the accept edge as E0. Simple op: valid_o high in cycle 1 (after E0) for exactly one cycle.
- MUL:
  - ready_o/busy_o change in cycle 1 and hold through cycle N.
  - Iteration edges are E1..EN; the result is produced at EN.
  - valid_o and ready_o = 1 both appear in cycle N+1. A new op may be accepted at the edge ending cycle N+1, giving back-to-back issue with no bubble.
- Back-to-back simple ops: one accept per cycle, with valid_o high continuously.
- ready_o and busy_o are registered (state-decoded only) and have no combinational path from valid_i.
- valid_o never asserts without a prior accept.

## Test plan
- Reset: assert rst_i asynchronously mid-cycle. Outputs go to their reset values immediately (ready_o = 1, valid_o = 0, result_o = 0, zero_o = 1) without waiting for a clock.
- ADD/SUB/zero: issue R-type ADD 5 + 7, then SUB 3 - 5 (ALUOp 01), then SUB 9 - 9, on consecutive cycles. Required: valid_o in cycles 1-3, results 12, 0xFFFFFFFE, 0 (zero_o = 1 only on the last), ready_o never drops.
- Decode coverage:
  - AND/OR/XOR/SLL on 0xF0F0_1234 and 0x0000_00FF: 0x34, 0xF0F0_12FF, 0xF0F0_12CB, and the shifted value.
  - SRAI of 0x8000_0000 by 4: 0xF800_0000.
  - ALUOp 10 with funct3 010: ADD result.
- MUL latency/stall (WIDTH 32, MUL_BITS 1): issue 6 * 7 with valid_i held high and a second ADD queued behind it.
  - Required: ready_o low in cycles 1-32.
  - valid_o with 42 in cycle 33.
  - The ADD is accepted at the end of cycle 33, and its result appears in cycle 34.
- MUL wrap: 0xFFFF_FFFF * 0xFFFF_FFFF -> 0x0000_0001. Then 0x1_0000 * 0x1_0000 -> 0 with zero_o = 1.
- Reset mid-MUL and parameter sweep:
  - Assert rst_i in cycle 10 of a multiply. No valid_o follows; the next op issued runs normally.
  - Rerun the 6 * 7 case with MUL_BITS 4: valid_o in cycle 9, result 42.
